keypad_debounce_bank: RTL and testbench
=======================================

// Module: keypad_debounce_bank
// PURPOSE
//  Parametrised multi-channel debouncer for the keypad scan path. Each channel has a 2-FF
//  synchroniser, a saturating debounce counter and press/release edge pulses.
//  A shared lockout arbiter turns confirmed presses into a single key event (index + one-hot).
//  The event is held for HOLD_CYCLES, like the single-button debouncer it replaces.
//  Sits between the keypad pins and the key decoder / display FSM.
// PARAMETERS
//  CHANNELS     4           number of independent raw inputs (>=1)
//  CNT_W        6           debounce counter width; DB_MAX = 2**CNT_W-1
//  HOLD_CYCLES  15_000_000  cycles key_valid stays asserted per event (>=1)
//  HOLD_W       32          hold counter width; must hold HOLD_CYCLES
// PORTS
//  clk          in   1            system clock
//  reset        in   1            synchronous, active-high reset
//  raw_in       in   CHANNELS     asynchronous raw key/column levels
//  stable_out   out  CHANNELS     debounced level per channel
//  rise_pulse   out  CHANNELS     1-cycle pulse on debounced 0->1
//  fall_pulse   out  CHANNELS     1-cycle pulse on debounced 1->0
//  key_valid    out  1            high while an accepted key event is held
//  key_strobe   out  1            1-cycle pulse on each accepted (or repeated) event
//  key_idx      out  IDX_W        index of accepted channel; IDX_W = max(1,$clog2(CHANNELS))
//  key_onehot   out  CHANNELS     one-hot of accepted channel, 0 when idle
//  overrun      out  1            sticky: a confirmed press was dropped
// BEHAVIOUR
//  - Reset: all outputs 0; sync FFs, counters and stable state 0; FSM in IDLE. Takes effect at
//    the next edge, mid-debounce or mid-HOLD included.
//  - Per channel: sync1<=raw; sync2<=sync1.
//    - sync2==stable: cnt<=0.
//    - Mismatch with cnt<DB_MAX: cnt++.
//    - Mismatch with cnt==DB_MAX: stable<=sync2, cnt<=0, rise/fall pulse asserted that same edge.
//    - Any single-cycle agreement restarts the count.
//  - Latency: stable_out changes DB_MAX+2 edges after the first edge that samples the new raw
//    level. Any pulse shorter than DB_MAX+1 cycles at sync2 is rejected.
//  - Arbiter FSM, IDLE / HOLD:
//    - IDLE, any rise_pulse: take lowest set index. Next edge: key_valid=1, key_strobe=1
//      (one cycle), key_idx/key_onehot latched, hold_cnt=0, go HOLD.
//    - Simultaneous rises in IDLE: lowest index wins; overrun<=1.
//    - HOLD: hold_cnt++ each cycle. key_valid stays high exactly HOLD_CYCLES cycles, then
//      key_valid=0, key_onehot=0, key_idx=0, go IDLE.
//    - rise_pulse in HOLD: ignored, no strobe, overrun<=1.
//    - A rise_pulse on the same edge HOLD exits is dropped, not accepted (no back-to-back
//      events); overrun<=1.
//  - fall_pulse never affects the FSM. Release during HOLD does not shorten the hold.
//  - overrun clears only on reset.
// CONFIGURATION
//  - KEYPAD_DEBOUNCE_AUTOREPEAT_EN defined: at HOLD expiry, if stable_out[key_idx] is still 1,
//    stay in HOLD with hold_cnt<=0 and pulse key_strobe. key_valid, key_idx and key_onehot are
//    unchanged (key_valid does not drop). Repeats every HOLD_CYCLES while held; release ends at
//    the next expiry.
//  - Not defined: expiry always returns to IDLE, one strobe per press.
// STRUCTURE
//  - Package keypad_debounce_pkg:
//    - arbiter state enum (IDLE, HOLD)
//    - function db_max(cnt_w)
//    - localparam helper for IDX_W
//  - Sub-module debounce_channel (sync + counter + edge pulses; params CNT_W), instantiated
//    CHANNELS times in a generate loop.
//  - Arbiter FSM and priority encoder live in the top module.
// TESTING (bench params: CHANNELS=4, CNT_W=3 -> DB_MAX=7, HOLD_CYCLES=20)
//  1 Clean press: raw_in[2]=1 held 60 cycles -> stable_out[2] rises 9 edges later;
//    rise_pulse[2] 1 cycle; key_strobe 1 cycle; key_valid high 20 cycles;
//    key_idx=2, key_onehot=4'b0100; fall_pulse[2] 9 edges after release.
//  2 Bounce: raw_in[0] toggles every 5 cycles for 100 cycles -> stable_out, pulses,
//    key_valid all stay 0.
//  3 Simultaneous: raw_in[1] and raw_in[3] rise same cycle -> key_idx=1,
//    key_onehot=4'b0010, overrun=1.
//  4 Press in HOLD: ch0 accepted, ch3 pressed 12 cycles later -> no second strobe,
//    key_idx stays 0, overrun=1.
//  5 Reset mid-HOLD: reset at hold cycle 10 -> next edge all outputs 0; new press on ch2
//    after release is accepted normally.
//  6 Repeat: ch0 held 70 cycles -> macro on: strobes at t, t+20, t+40, t+60, key_valid
//    continuous; macro off: one strobe, key_valid low after 20.

Source files
------------

// File: rtl/keypad_debounce_pkg.sv
// rtl/keypad_debounce_pkg.sv - shared types and helpers for the keypad debounce bank
package keypad_debounce_pkg;

   // Key-event arbiter states
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   // Narrowest index width, even for a single channel
   localparam int MIN_IDX_W = 1;

   // Saturation value of a debounce counter of the given width
   function automatic int db_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

   // Width of the key index for a given channel count
   function automatic int idx_w(input int channels);
      return (channels > 1) ? $clog2(channels) : MIN_IDX_W;
   endfunction

endpackage

// File: rtl/keypad_debounce_bank_channel.sv
// rtl/keypad_debounce_bank_channel.sv - one synchronised, debounced key input with edge pulses
module debounce_channel
   import keypad_debounce_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic stable_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(db_max(CNT_W));

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser for the asynchronous pin level
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after DB_MAX+1 consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         stable_out <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         if (sync2 == stable_out) begin
            cnt <= '0;
         end else if (cnt != DB_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            stable_out <= sync2;
            cnt        <= '0;
            rise_pulse <= sync2;
            fall_pulse <= ~sync2;
         end
      end
   end

endmodule

// File: rtl/keypad_debounce_bank.sv
// rtl/keypad_debounce_bank.sv - multi-channel key debouncer with lockout event arbiter (KEYPAD_DEBOUNCE_AUTOREPEAT_EN)
module keypad_debounce_bank
   import keypad_debounce_pkg::*;
#(
   parameter  int CHANNELS    = 4,
   parameter  int CNT_W       = 6,
   parameter  int HOLD_CYCLES = 15_000_000,
   parameter  int HOLD_W      = 32,
   localparam int IDX_W       = idx_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] stable_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic                key_valid,
   output logic                key_strobe,
   output logic [IDX_W-1:0]    key_idx,
   output logic [CHANNELS-1:0] key_onehot,
   output logic                overrun
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   arb_state_t          state, state_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
   logic                key_valid_n;
   logic                key_strobe_n;
   logic [IDX_W-1:0]    key_idx_n;
   logic [CHANNELS-1:0] key_onehot_n;
   logic                overrun_n;

   logic                rise_any;
   logic                rise_multi;
   logic [IDX_W-1:0]    win_idx;
   logic [CHANNELS-1:0] win_onehot;
   logic                repeat_ok;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_chan
         debounce_channel #(
            .CNT_W (CNT_W)
         ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .raw_in     (raw_in[g]),
            .stable_out (stable_out[g]),
            .rise_pulse (rise_pulse[g]),
            .fall_pulse (fall_pulse[g])
         );
      end
   endgenerate

   // Lowest-index priority encoder over this cycle's confirmed presses
   always_comb begin
      win_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (rise_pulse[i]) begin
            win_idx = IDX_W'(i);
         end
      end
      win_onehot = CHANNELS'(1) << win_idx;
      rise_any   = |rise_pulse;
      rise_multi = (rise_pulse & (rise_pulse - CHANNELS'(1))) != '0;
   end

   // Whether an expiring event may restart because its key is still down
`ifdef KEYPAD_DEBOUNCE_AUTOREPEAT_EN
   assign repeat_ok = |(stable_out & key_onehot);
`else
   assign repeat_ok = 1'b0;
`endif

   // Arbiter next-state: accept one press, lock out others until the hold expires
   always_comb begin
      state_n      = state;
      hold_cnt_n   = hold_cnt;
      key_valid_n  = key_valid;
      key_strobe_n = 1'b0;
      key_idx_n    = key_idx;
      key_onehot_n = key_onehot;
      overrun_n    = overrun;
      unique case (state)
         IDLE: begin
            if (rise_any) begin
               state_n      = HOLD;
               hold_cnt_n   = '0;
               key_valid_n  = 1'b1;
               key_strobe_n = 1'b1;
               key_idx_n    = win_idx;
               key_onehot_n = win_onehot;
               if (rise_multi) begin
                  overrun_n = 1'b1;
               end
            end
         end
         HOLD: begin
            // Presses during the hold, including on the expiry edge, are dropped
            if (rise_any) begin
               overrun_n = 1'b1;
            end
            if (hold_cnt == HOLD_LAST) begin
               if (repeat_ok) begin
                  hold_cnt_n   = '0;
                  key_strobe_n = 1'b1;
               end else begin
                  state_n      = IDLE;
                  key_valid_n  = 1'b0;
                  key_idx_n    = '0;
                  key_onehot_n = '0;
               end
            end else begin
               hold_cnt_n = hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Arbiter state and registered event outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         hold_cnt   <= '0;
         key_valid  <= 1'b0;
         key_strobe <= 1'b0;
         key_idx    <= '0;
         key_onehot <= '0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_n;
         hold_cnt   <= hold_cnt_n;
         key_valid  <= key_valid_n;
         key_strobe <= key_strobe_n;
         key_idx    <= key_idx_n;
         key_onehot <= key_onehot_n;
         overrun    <= overrun_n;
      end
   end

endmodule

// File: tb/tb_keypad_debounce_bank.sv
// tb/tb_keypad_debounce_bank.sv - randomized self-checking bench for keypad_debounce_bank
module tb_keypad_debounce_bank;

   localparam int CH     = 4;
   localparam int CNT_W  = 3;
   localparam int DBM    = 7;
   localparam int HOLD   = 20;
   localparam int HOLD_W = 32;
   localparam int IDX_W  = 2;
`ifdef KEYPAD_DEBOUNCE_AUTOREPEAT_EN
   localparam bit AUTOREP = 1'b1;
`else
   localparam bit AUTOREP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [CH-1:0]    raw_in;
   logic [CH-1:0]    stable_out;
   logic [CH-1:0]    rise_pulse;
   logic [CH-1:0]    fall_pulse;
   logic             key_valid;
   logic             key_strobe;
   logic [IDX_W-1:0] key_idx;
   logic [CH-1:0]    key_onehot;
   logic             overrun;

   always #5 clk = ~clk;

   keypad_debounce_bank #(
      .CHANNELS    (CH),
      .CNT_W       (CNT_W),
      .HOLD_CYCLES (HOLD),
      .HOLD_W      (HOLD_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .raw_in     (raw_in),
      .stable_out (stable_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .key_valid  (key_valid),
      .key_strobe (key_strobe),
      .key_idx    (key_idx),
      .key_onehot (key_onehot),
      .overrun    (overrun)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
   endtask

   // Reference model: pin level reaches the debouncer two edges later; a level is accepted
   // once the last DBM+1 synchronised samples all disagree with the current stable level.
   // A key event lasts HOLD edges from its acceptance edge.
   logic [CH-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
   logic [DBM:0]  m_hist [CH];
   logic          m_busy, m_strobe, m_over;
   int            m_idx, m_expire;

   task automatic model_edge(input logic rst, input logic [CH-1:0] raw);
      logic [CH-1:0] rise_prev, stable_prev;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
         for (int c = 0; c < CH; c++) m_hist[c] = '0;
         m_busy = 1'b0; m_strobe = 1'b0; m_over = 1'b0; m_idx = 0; m_expire = 0;
         return;
      end
      rise_prev   = m_rise;
      stable_prev = m_stable;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
         m_hist[c] = {m_hist[c][DBM-1:0], m_s2[c]};
         if (m_hist[c] == {(DBM+1){~m_stable[c]}}) begin
            m_stable[c] = ~m_stable[c];
            if (m_stable[c]) m_rise[c] = 1'b1;
            else             m_fall[c] = 1'b1;
         end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_strobe = 1'b0;
      if (!m_busy) begin
         if (rise_prev != '0) begin
            for (int c = 0; c < CH; c++) begin
               if (rise_prev[c]) begin
                  m_idx = c;
                  break;
               end
            end
            m_busy   = 1'b1;
            m_strobe = 1'b1;
            m_expire = cyc + HOLD;
            if ($countones(rise_prev) > 1) m_over = 1'b1;
         end
      end else begin
         if (rise_prev != '0) m_over = 1'b1;
         if (cyc == m_expire) begin
            if (AUTOREP && stable_prev[m_idx]) begin
               m_expire = cyc + HOLD;
               m_strobe = 1'b1;
            end else begin
               m_busy = 1'b0;
               m_idx  = 0;
            end
         end
      end
   endtask

   task automatic step(input logic rst, input logic [CH-1:0] raw);
      logic [CH-1:0] exp_onehot;
      reset  = rst;
      raw_in = raw;
      @(posedge clk);
      cyc++;
      #1;
      model_edge(rst, raw);
      exp_onehot = m_busy ? CH'(1) << m_idx : '0;
      check_eq("stable_out", 32'(stable_out), 32'(m_stable));
      check_eq("rise_pulse", 32'(rise_pulse), 32'(m_rise));
      check_eq("fall_pulse", 32'(fall_pulse), 32'(m_fall));
      check_eq("key_valid",  32'(key_valid),  32'(m_busy));
      check_eq("key_strobe", 32'(key_strobe), 32'(m_strobe));
      check_eq("key_idx",    32'(key_idx),    32'(m_busy ? m_idx : 0));
      check_eq("key_onehot", 32'(key_onehot), 32'(exp_onehot));
      check_eq("overrun",    32'(overrun),    32'(m_over));
   endtask

   initial begin
      int rise_at, fall_at, valid_len, strobes, mode;
      logic [CH-1:0] raw;
      reset  = 1'b1;
      raw_in = '0;

      repeat (3) step(1'b1, '0);
      check_eq("reset_outputs", 32'({stable_out, key_valid, key_strobe, key_onehot, overrun}), 32'd0);

      // Clean press on channel 2, held 60 cycles then released
      rise_at = -1; fall_at = -1; valid_len = 0; strobes = 0;
      for (int i = 1; i <= 60; i++) begin
         step(1'b0, 4'b0100);
         if (stable_out[2] && rise_at < 0) rise_at = i;
         if (key_valid) valid_len++;
         if (key_strobe) begin
            strobes++;
            check_eq("press_onehot", 32'(key_onehot), 32'(4'b0100));
            check_eq("press_idx", 32'(key_idx), 32'd2);
         end
      end
      for (int i = 1; i <= 40; i++) begin
         step(1'b0, '0);
         if (fall_pulse[2] && fall_at < 0) fall_at = i;
         if (key_valid) valid_len++;
         if (key_strobe) strobes++;
      end
      check_eq("press_latency", 32'(rise_at - 1), 32'(DBM + 2));
      check_eq("release_latency", 32'(fall_at - 1), 32'(DBM + 2));
      check_eq("press_valid_len", 32'(valid_len), AUTOREP ? 32'd60 : 32'(HOLD));
      check_eq("press_strobes", 32'(strobes), AUTOREP ? 32'd3 : 32'd1);

      // Randomized segments: slow presses, heavy bounce, simultaneous presses, rare resets
      raw = '0;
      for (int seg = 0; seg < 30; seg++) begin
         mode = $urandom_range(0, 2);
         if (mode == 2) begin
            raw = '0;
            repeat (30) step(1'b0, raw);
            raw = CH'(1) << $urandom_range(0, CH - 1);
            raw = raw | (CH'(1) << $urandom_range(0, CH - 1));
         end
         for (int i = 0; i < 100; i++) begin
            for (int c = 0; c < CH; c++) begin
               if (mode == 0 && $urandom_range(0, 29) == 0) raw[c] = ~raw[c];
               if (mode == 1 && $urandom_range(0, 2) == 0)  raw[c] = ~raw[c];
            end
            step($urandom_range(0, 399) == 0, raw);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
